// File: rtl/deck_pkg.sv
// Shared definitions for the card dealer: deck size, card width,
// dealer state encoding and the probe wrap helper.
package deck_pkg;

  localparam int NUM_CARDS = 52;
  localparam int CARD_W    = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PULSE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_PROBE = 3'd4
  } dealer_state_t;

  // Next card in linear probe order, wrapping from the last card back to 1.
  function automatic logic [CARD_W-1:0] next_card(input logic [CARD_W-1:0] idx);
    if (idx == CARD_W'(NUM_CARDS)) begin
      return CARD_W'(1);
    end else begin
      return idx + CARD_W'(1);
    end
  endfunction

endpackage

// File: rtl/card_dealer_if.sv
// Dealer handshake bundle: RNG strobe/value, deal requests and deck status.
interface card_dealer_if;
  import deck_pkg::*;

  logic              new_deck;
  logic              deal_req;
  logic [15:0]       rand_int;
  logic              next_int;
  logic [CARD_W-1:0] card;
  logic              card_valid;
  logic              deal_err;
  logic              busy;
  logic [CARD_W-1:0] cards_left;
  logic              deck_empty;

  modport master (
    output new_deck, deal_req, rand_int,
    input  next_int, card, card_valid, deal_err, busy, cards_left, deck_empty
  );

  modport slave (
    input  new_deck, deal_req, rand_int,
    output next_int, card, card_valid, deal_err, busy, cards_left, deck_empty
  );

endinterface

// File: rtl/card_mask.sv
// Dealt-card set: bit i marks card i+1 as dealt. Also keeps the count of
// undealt cards so it always agrees with the set.
module card_mask
  import deck_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_all,
  input  logic              set_en,
  input  logic [CARD_W-1:0] idx,
  output logic              is_dealt,
  output logic [CARD_W-1:0] cards_left
);

  logic [NUM_CARDS-1:0] r_mask;
  logic [CARD_W-1:0]    r_cards_left;
  logic [CARD_W-1:0]    w_bit;
  logic                 w_in_range;

  assign w_in_range = (idx >= CARD_W'(1)) && (idx <= CARD_W'(NUM_CARDS));
  assign w_bit      = idx - CARD_W'(1);
  // Out-of-range indices read as dealt so they can never be accepted.
  assign is_dealt   = w_in_range ? r_mask[w_bit] : 1'b1;
  assign cards_left = r_cards_left;

  // Track the dealt set and remaining count; clearing wins over setting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mask       <= '0;
      r_cards_left <= CARD_W'(NUM_CARDS);
    end else if (clear_all) begin
      r_mask       <= '0;
      r_cards_left <= CARD_W'(NUM_CARDS);
    end else if (set_en && w_in_range && !r_mask[w_bit]) begin
      r_mask[w_bit] <= 1'b1;
      r_cards_left  <= r_cards_left - CARD_W'(1);
    end else begin
      r_mask       <= r_mask;
      r_cards_left <= r_cards_left;
    end
  end

endmodule

// File: rtl/card_dealer.sv
// Card dealer: draws unique cards 1..52 from the RNG, retrying rejected
// draws and falling back to a linear probe so every deal is bounded.
module card_dealer
  import deck_pkg::*;
#(
  parameter int RNG_WAIT  = 2,
  parameter int MAX_RETRY = 8
)(
  input  logic         clock,
  input  logic         reset,
  card_dealer_if.slave bus
);

  localparam logic [7:0] RNG_WAIT_C  = 8'(RNG_WAIT);
  localparam logic [7:0] MAX_RETRY_C = 8'(MAX_RETRY);

  dealer_state_t     r_state;
  logic              r_next_int;
  logic [CARD_W-1:0] r_card;
  logic              r_card_valid;
  logic              r_deal_err;
  logic [7:0]        r_retry_cnt;
  logic [7:0]        r_wait_cnt;
  logic [CARD_W-1:0] r_probe;

  logic              w_cand_ok;
  logic [CARD_W-1:0] w_cand;
  logic [CARD_W-1:0] w_query_idx;
  logic              w_is_dealt;
  logic              w_accept;
  logic [CARD_W-1:0] w_cards_left;
  logic              w_deck_empty;

  // Range test uses all 16 bits so large values cannot alias onto a card.
  assign w_cand_ok    = (bus.rand_int >= 16'd1) && (bus.rand_int <= 16'(NUM_CARDS));
  assign w_cand       = bus.rand_int[CARD_W-1:0];
  assign w_query_idx  = (r_state == ST_PROBE) ? r_probe : w_cand;
  assign w_accept     = !bus.new_deck && !w_is_dealt &&
                        (((r_state == ST_CHECK) && w_cand_ok) || (r_state == ST_PROBE));
  assign w_deck_empty = (w_cards_left == CARD_W'(0));

  card_mask u_mask (
    .clock      (clock),
    .reset      (reset),
    .clear_all  (bus.new_deck),
    .set_en     (w_accept),
    .idx        (w_query_idx),
    .is_dealt   (w_is_dealt),
    .cards_left (w_cards_left)
  );

  assign bus.next_int   = r_next_int;
  assign bus.card       = r_card;
  assign bus.card_valid = r_card_valid;
  assign bus.deal_err   = r_deal_err;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.cards_left = w_cards_left;
  assign bus.deck_empty = w_deck_empty;

  // Dealer sequencing: strobe RNG, wait, check draw, retry or probe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_next_int   <= 1'b0;
      r_card       <= '0;
      r_card_valid <= 1'b0;
      r_deal_err   <= 1'b0;
      r_retry_cnt  <= 8'd0;
      r_wait_cnt   <= 8'd0;
      r_probe      <= CARD_W'(1);
    end else begin
      r_card_valid <= 1'b0;
      r_deal_err   <= 1'b0;
      if (bus.new_deck) begin
        // New deck aborts any deal in flight; the mask clears itself.
        r_state    <= ST_IDLE;
        r_next_int <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.deal_req && w_deck_empty) begin
              r_deal_err <= 1'b1;
            end else if (bus.deal_req) begin
              r_retry_cnt <= 8'd0;
              r_next_int  <= 1'b1;
              r_state     <= ST_PULSE;
            end else begin
              r_state <= ST_IDLE;
            end
          end
          ST_PULSE: begin
            r_next_int <= 1'b0;
            r_wait_cnt <= 8'd0;
            r_state    <= ST_WAIT;
          end
          ST_WAIT: begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
            if ((r_wait_cnt + 8'd1) >= RNG_WAIT_C) begin
              r_state <= ST_CHECK;
            end else begin
              r_state <= ST_WAIT;
            end
          end
          ST_CHECK: begin
            if (w_accept) begin
              r_card       <= w_cand;
              r_card_valid <= 1'b1;
              r_state      <= ST_IDLE;
            end else if ((r_retry_cnt + 8'd1) < MAX_RETRY_C) begin
              r_retry_cnt <= r_retry_cnt + 8'd1;
              r_next_int  <= 1'b1;
              r_state     <= ST_PULSE;
            end else begin
              r_retry_cnt <= r_retry_cnt + 8'd1;
              r_probe     <= w_cand_ok ? w_cand : CARD_W'(1);
              r_state     <= ST_PROBE;
            end
          end
          ST_PROBE: begin
            if (w_accept) begin
              r_card       <= r_probe;
              r_card_valid <= 1'b1;
              r_state      <= ST_IDLE;
            end else begin
              r_probe <= next_card(r_probe);
            end
          end
          default: begin
            r_state    <= ST_IDLE;
            r_next_int <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: directed table of deals, random
// full-deck deal against a reference model, abort and reset sequences.
module tb_card_dealer;
  import deck_pkg::*;

  localparam int RNG_WAIT  = 2;
  localparam int MAX_RETRY = 8;
  localparam int DRAW_CYC  = RNG_WAIT + 2;

  logic clock = 1'b0;
  logic reset;

  card_dealer_if bus();

  card_dealer #(.RNG_WAIT(RNG_WAIT), .MAX_RETRY(MAX_RETRY)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] rng_q[$];
  bit          ref_dealt[NUM_CARDS+1];
  int          ref_left;

  typedef struct packed {
    logic        nd;
    logic [15:0] r0, r1, r2, r3;
    int          n;
    int          card;
    int          draws;
    int          lat;
    int          left;
  } vec_t;

  vec_t tbl[11];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // RNG model: value for the d-th draw of a deal, last value sticks.
  function automatic logic [15:0] rng_val(input int d);
    if (d < rng_q.size()) return rng_q[d];
    return rng_q[rng_q.size()-1];
  endfunction

  function automatic void ref_reset();
    for (int i = 0; i <= NUM_CARDS; i++) ref_dealt[i] = 1'b0;
    ref_left = NUM_CARDS;
  endfunction

  // Reference deal: up to MAX_RETRY draws, then scan upward with wrap.
  function automatic void ref_deal(output int card, output int draws, output int probes);
    int cand, p;
    card = 0; draws = 0; probes = 0; cand = 0;
    for (int d = 0; d < MAX_RETRY && card == 0; d++) begin
      cand  = int'(rng_val(d));
      draws = d + 1;
      if (cand >= 1 && cand <= NUM_CARDS) begin
        if (!ref_dealt[cand]) card = cand;
      end
    end
    if (card == 0) begin
      p = (cand >= 1 && cand <= NUM_CARDS) ? cand : 1;
      for (int k = 1; k <= NUM_CARDS && card == 0; k++) begin
        probes = k;
        if (!ref_dealt[p]) card = p;
        else p = (p == NUM_CARDS) ? 1 : p + 1;
      end
    end
    if (card != 0) begin
      ref_dealt[card] = 1'b1;
      ref_left--;
    end
  endfunction

  function automatic logic [15:0] rnd_val();
    int sel;
    sel = int'($urandom_range(0, 9));
    if (sel < 7) return 16'($urandom_range(1, 52));
    else if (sel == 7) return 16'd0;
    else if (sel == 8) return 16'd53;
    else return 16'($urandom_range(54, 65535));
  endfunction

  // One deal: raise deal_req for one edge, serve RNG strobes, await card_valid.
  task automatic run_deal(output int card, output int lat, output int strobes,
                          output int left, output int empty, output int after,
                          output int tmo);
    card = 0; lat = 0; strobes = 0; left = 0; empty = 0; after = 0; tmo = 1;
    bus.deal_req = 1'b1;
    step();
    bus.deal_req = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bus.next_int) begin
        bus.rand_int = rng_val(strobes);
        strobes++;
      end
      if (bus.card_valid) begin
        lat   = i;
        card  = int'(bus.card);
        left  = int'(bus.cards_left);
        empty = int'(bus.deck_empty);
        tmo   = 0;
        break;
      end
      step();
    end
    step();
    after = int'(bus.card_valid);
  endtask

  task automatic deal_check(input string tag, input int e_card, input int e_draws,
                            input int e_lat, input int e_left);
    int card, lat, strobes, left, empty, after, tmo;
    run_deal(card, lat, strobes, left, empty, after, tmo);
    check({tag, " timeout"}, tmo, 0);
    if (tmo == 0) begin
      check({tag, " card"}, card, e_card);
      check({tag, " latency"}, lat, e_lat);
      check({tag, " strobes"}, strobes, e_draws);
      check({tag, " cards_left"}, left, e_left);
      check({tag, " deck_empty"}, empty, (e_left == 0) ? 1 : 0);
      check({tag, " valid_pulse"}, after, 0);
    end
  endtask

  task automatic pulse_new_deck();
    bus.new_deck = 1'b1;
    step();
    bus.new_deck = 1'b0;
  endtask

  initial begin
    int c, d, p, n, seen;

    tbl[0]  = '{1'b0, 16'd17, 16'd0,   16'd0,  16'd0, 1, 17, 1, 4,  51};
    tbl[1]  = '{1'b0, 16'd17, 16'd17,  16'd30, 16'd0, 3, 30, 3, 12, 50};
    tbl[2]  = '{1'b0, 16'd1,  16'd0,   16'd0,  16'd0, 1, 1,  1, 4,  49};
    tbl[3]  = '{1'b0, 16'd2,  16'd0,   16'd0,  16'd0, 1, 2,  1, 4,  48};
    tbl[4]  = '{1'b0, 16'd3,  16'd0,   16'd0,  16'd0, 1, 3,  1, 4,  47};
    tbl[5]  = '{1'b0, 16'd0,  16'd0,   16'd0,  16'd0, 1, 4,  8, 36, 46};
    tbl[6]  = '{1'b0, 16'd65, 16'd261, 16'd53, 16'd5, 4, 5,  4, 16, 45};
    tbl[7]  = '{1'b1, 16'd50, 16'd0,   16'd0,  16'd0, 1, 50, 1, 4,  51};
    tbl[8]  = '{1'b0, 16'd51, 16'd0,   16'd0,  16'd0, 1, 51, 1, 4,  50};
    tbl[9]  = '{1'b0, 16'd52, 16'd0,   16'd0,  16'd0, 1, 52, 1, 4,  49};
    tbl[10] = '{1'b0, 16'd51, 16'd0,   16'd0,  16'd0, 1, 1,  8, 35, 48};

    reset = 1'b1;
    bus.new_deck = 1'b0;
    bus.deal_req = 1'b0;
    bus.rand_int = 16'd0;
    repeat (3) step();
    reset = 1'b0;
    step();

    check("reset card", int'(bus.card), 0);
    check("reset cards_left", int'(bus.cards_left), 52);
    check("reset deck_empty", int'(bus.deck_empty), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset next_int", int'(bus.next_int), 0);
    check("reset card_valid", int'(bus.card_valid), 0);
    check("reset deal_err", int'(bus.deal_err), 0);

    // Directed deal table.
    for (int t = 0; t < 11; t++) begin
      if (tbl[t].nd) begin
        pulse_new_deck();
        check($sformatf("tbl%0d new_deck left", t), int'(bus.cards_left), 52);
      end
      rng_q = {};
      rng_q.push_back(tbl[t].r0);
      if (tbl[t].n > 1) rng_q.push_back(tbl[t].r1);
      if (tbl[t].n > 2) rng_q.push_back(tbl[t].r2);
      if (tbl[t].n > 3) rng_q.push_back(tbl[t].r3);
      deal_check($sformatf("tbl%0d", t), tbl[t].card, tbl[t].draws, tbl[t].lat, tbl[t].left);
    end

    // Random full-deck deal against the reference model.
    pulse_new_deck();
    ref_reset();
    for (int k = 0; k < NUM_CARDS; k++) begin
      rng_q = {};
      n = int'($urandom_range(1, 3));
      for (int j = 0; j < n; j++) rng_q.push_back(rnd_val());
      ref_deal(c, d, p);
      deal_check($sformatf("rand%0d", k), c, d, d * DRAW_CYC + p, ref_left);
    end

    // Empty deck: deal_req gives deal_err only.
    bus.deal_req = 1'b1;
    step();
    bus.deal_req = 1'b0;
    check("empty deal_err", int'(bus.deal_err), 1);
    check("empty next_int", int'(bus.next_int), 0);
    check("empty busy", int'(bus.busy), 0);
    step();
    check("empty deal_err drop", int'(bus.deal_err), 0);

    // new_deck while waiting on the RNG aborts the deal.
    pulse_new_deck();
    check("nd cards_left", int'(bus.cards_left), 52);
    rng_q = {16'd9};
    deal_check("nd first", 9, 1, 4, 51);
    bus.deal_req = 1'b1;
    step();
    bus.deal_req = 1'b0;
    step();
    check("nd in wait busy", int'(bus.busy), 1);
    bus.new_deck = 1'b1;
    step();
    bus.new_deck = 1'b0;
    check("nd abort busy", int'(bus.busy), 0);
    check("nd abort next_int", int'(bus.next_int), 0);
    check("nd abort cards_left", int'(bus.cards_left), 52);
    check("nd abort card", int'(bus.card), 9);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.card_valid || bus.deal_err) seen++;
      step();
    end
    check("nd abort no pulses", seen, 0);
    deal_check("nd fresh", 9, 1, 4, 51);

    // Asynchronous reset in the middle of a probe.
    for (int k = 1; k <= 5; k++) begin
      rng_q = {16'(k)};
      deal_check($sformatf("pre%0d", k), k, 1, 4, 51 - k);
    end
    bus.rand_int = 16'd0;
    bus.deal_req = 1'b1;
    step();
    bus.deal_req = 1'b0;
    repeat (34) step();
    check("probe busy", int'(bus.busy), 1);
    check("probe no valid yet", int'(bus.card_valid), 0);
    reset = 1'b1;
    #1;
    check("arst busy", int'(bus.busy), 0);
    check("arst cards_left", int'(bus.cards_left), 52);
    check("arst next_int", int'(bus.next_int), 0);
    check("arst card", int'(bus.card), 0);
    check("arst card_valid", int'(bus.card_valid), 0);
    step();
    step();
    reset = 1'b0;
    step();
    rng_q = {16'd1};
    deal_check("arst fresh", 1, 1, 4, 51);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
